psk_frame_sched: RTL and testbench

// - Frame scheduler ahead of the BPSK/QPSK modulator, in the 16.384 MHz domain.
// - Per frame it sequences: BPSK preamble -> BPSK 16-bit length header -> QPSK payload -> idle gap.
// - Drives the modulator's AXIS symbol input (tdata/tuser/tlast) and pulls payload bytes from the TX FIFO.

---
 rtl/psk_frame_sched.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_psk_frame_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_frame_sched.sv
// Frame scheduler ahead of the BPSK/QPSK modulator: preamble, 16-bit length header, payload, idle gap.
// Define PSK_SCHED_SCRAMBLE_EN to XOR payload bytes with an x^7+x^4+1 additive scrambler (seed 7'h7F).
module psk_frame_sched #(
  parameter int unsigned PREAMBLE_LEN  = 32,
  parameter logic [31:0] PREAMBLE_WORD = 32'hF3A5_0C5A,
  parameter int unsigned GAP_SYMS      = 8
) (
  input  logic        clk_16M384,
  input  logic        rstn_16M384,
  input  logic        start,
  input  logic [15:0] frame_len,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        underrun_err,
  input  logic        clear_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] fetched_q, fetched_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;
  logic [1:0]  pair_q, pair_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        slot_free_s, pre_last_s, hdr_last_s, pay_last_s;
  logic        gap_pulse_s, gap_last_s, fetch_s, pre_bit_s, hdr_bit_s;
  logic [4:0]  pre_idx_s;
  logic [3:0]  hdr_idx_s;
  logic [1:0]  pair_bits_s;
  logic [7:0]  ks_s;

  // A slot is free when nothing is presented or the modulator consumes this cycle
  assign slot_free_s = !tvalid_q || m_tready;
  assign pre_last_s  = (cnt_q == 16'(PREAMBLE_LEN - 1));
  assign hdr_last_s  = (cnt_q == 16'd15);
  assign gap_last_s  = (cnt_q == 16'(GAP_SYMS - 1));
  assign gap_pulse_s = m_tready && !tvalid_q;
  assign pre_idx_s   = 5'(PREAMBLE_LEN - 1) - cnt_q[4:0];
  assign hdr_idx_s   = 4'd15 - cnt_q[3:0];
  assign pre_bit_s   = PREAMBLE_WORD[pre_idx_s];
  assign hdr_bit_s   = len_q[hdr_idx_s];
  // The buffered byte is the frame's last one once every byte has been fetched
  assign pay_last_s  = buf_vld_q && (pair_q == 2'd3) && (fetched_q == len_q);
  assign s_tready    = !buf_vld_q && (state_q == S_PAY) && (fetched_q < len_q);
  assign fetch_s     = s_tvalid && s_tready;

  always_comb begin
    case (pair_q)
      2'd0:    pair_bits_s = buf_q[7:6];
      2'd1:    pair_bits_s = buf_q[5:4];
      2'd2:    pair_bits_s = buf_q[3:2];
      default: pair_bits_s = buf_q[1:0];
    endcase
  end

`ifdef PSK_SCHED_SCRAMBLE_EN
  logic [6:0] lfsr_q, lfsr_d;

  function automatic logic [7:0] lfsr_ks8(input logic [6:0] seed);
    logic [6:0] l;
    logic [7:0] ks;
    l = seed;
    for (int i = 7; i >= 0; i--) begin
      ks[i] = l[6];
      l = {l[5:0], l[6] ^ l[3]};
    end
    return ks;
  endfunction

  function automatic logic [6:0] lfsr_adv8(input logic [6:0] seed);
    logic [6:0] l;
    l = seed;
    for (int i = 0; i < 8; i++) begin
      l = {l[5:0], l[6] ^ l[3]};
    end
    return l;
  endfunction

  assign ks_s = lfsr_ks8(lfsr_q);

  // Scrambler reseeds outside PAY and steps one byte per fetched byte
  always_comb begin
    if (state_q != S_PAY) begin
      lfsr_d = 7'h7F;
    end else if (fetch_s) begin
      lfsr_d = lfsr_adv8(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      lfsr_q <= 7'h7F;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign ks_s = 8'h00;
`endif

  // State register
  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PRE; else state_d = S_IDLE;
      S_PRE:  if (slot_free_s && pre_last_s) state_d = S_HDR; else state_d = S_PRE;
      S_HDR: begin
        if (slot_free_s && hdr_last_s) begin
          state_d = (len_q == 16'd0) ? S_GAP : S_PAY;
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAY:  if (slot_free_s && pay_last_s) state_d = S_GAP; else state_d = S_PAY;
      S_GAP:  if (gap_pulse_s && gap_last_s) state_d = S_IDLE; else state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Symbol, counter and byte-buffer next values
  always_comb begin
    len_d     = len_q;
    cnt_d     = cnt_q;
    fetched_d = fetched_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    pair_d    = pair_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start) begin
          len_d     = frame_len;
          fetched_d = 16'd0;
          buf_vld_d = 1'b0;
          pair_d    = 2'd0;
        end else begin
          len_d = len_q;
        end
      end
      S_PRE: begin
        if (slot_free_s) begin
          tdata_d  = {6'd0, pre_bit_s, pre_bit_s};
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = 1'b0;
          cnt_d    = pre_last_s ? 16'd0 : cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_HDR: begin
        if (slot_free_s) begin
          tdata_d  = {6'd0, hdr_bit_s, hdr_bit_s};
          tvalid_d = 1'b1;
          tuser_d  = 1'b1;
          tlast_d  = (len_q == 16'd0) && hdr_last_s;
          cnt_d    = hdr_last_s ? 16'd0 : cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PAY: begin
        if (slot_free_s && buf_vld_q) begin
          tdata_d  = {6'd0, pair_bits_s};
          tvalid_d = 1'b1;
          tuser_d  = 1'b0;
          tlast_d  = pay_last_s;
          pair_d   = pair_q + 2'd1;
          buf_vld_d = (pair_q != 2'd3);
        end else if (slot_free_s) begin
          // Underrun: present nothing and keep the pair index where it is
          tdata_d  = 8'd0;
          tvalid_d = 1'b0;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
        if (fetch_s) begin
          buf_d     = s_tdata ^ ks_s;
          buf_vld_d = 1'b1;
          fetched_d = fetched_q + 16'd1;
        end else begin
          fetched_d = fetched_q;
        end
      end
      S_GAP: begin
        if (m_tready) begin
          tdata_d  = 8'd0;
          tvalid_d = 1'b0;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
        if (gap_pulse_s) begin
          cnt_d = gap_last_s ? 16'd0 : cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = 16'd0;
      end
    endcase
  end

  // Done pulse and sticky underrun flag (clear has priority over set)
  always_comb begin
    done_d = (state_q == S_GAP) && (state_d == S_IDLE);
    if (clear_err) begin
      err_d = 1'b0;
    end else if ((state_q == S_PAY) && m_tready && !tvalid_q) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      len_q     <= 16'd0;
      cnt_q     <= 16'd0;
      fetched_q <= 16'd0;
      buf_q     <= 8'd0;
      buf_vld_q <= 1'b0;
      pair_q    <= 2'd0;
      tdata_q   <= 8'd0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      fetched_q <= fetched_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      pair_q    <= pair_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign m_tdata      = tdata_q;
  assign m_tvalid     = tvalid_q;
  assign m_tlast      = tlast_q;
  assign m_tuser      = tuser_q;
  assign underrun_err = err_q;

endmodule

// File: tb/tb_psk_frame_sched.sv
// Self-checking bench for psk_frame_sched: randomized frames compared slot-by-slot
// against a symbol-list reference model built from the frame format.
module tb_psk_frame_sched;

  localparam logic [31:0] PW  = 32'hF3A5_0C5A;
  localparam int          PL  = 32;
  localparam int          GAP = 8;
`ifdef PSK_SCHED_SCRAMBLE_EN
  localparam bit SCR_EN = 1'b1;
`else
  localparam bit SCR_EN = 1'b0;
`endif

  logic        clk_16M384 = 1'b0;
  logic        rstn_16M384;
  logic        start;
  logic [15:0] frame_len;
  logic        busy, done;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic        underrun_err, clear_err;

  psk_frame_sched dut (
    .clk_16M384   (clk_16M384),
    .rstn_16M384  (rstn_16M384),
    .start        (start),
    .frame_len    (frame_len),
    .busy         (busy),
    .done         (done),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .underrun_err (underrun_err),
    .clear_err    (clear_err)
  );

  always #5 clk_16M384 = ~clk_16M384;

  typedef struct packed {
    logic       v;
    logic       u;
    logic       l;
    logic [1:0] d;
  } slot_t;

  slot_t      exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pay_bytes[$];
  int errs = 0, checks = 0;
  int pulses_done, byte_idx, hold_idx, hold_until, accepted, tready_cycles;
  logic acc_s, obs_done, obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keystream byte j: o[n] = o[n-7] ^ o[n-4], first 7 bits are the all-ones seed
  function automatic logic [7:0] ks_byte(input int j);
    bit o[$];
    logic [7:0] r;
    for (int n = 0; n < 8 * j + 8; n++) begin
      if (n < 7) o.push_back(1'b1);
      else       o.push_back(o[n-7] ^ o[n-4]);
    end
    for (int b = 0; b < 8; b++) r[7-b] = o[8*j+b];
    return SCR_EN ? r : 8'h00;
  endfunction

  // One clock: sample at negedge (checking any consumed slot), then drive FIFO after posedge
  task automatic tick(input logic rdy);
    slot_t e;
    m_tready = rdy;
    @(negedge clk_16M384);
    acc_s    = s_tvalid & s_tready;
    obs_done = done;
    obs_busy = busy;
    if (s_tready) tready_cycles++;
    if (rdy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.v) chk($sformatf("slot%0d", pulses_done), {21'd0, m_tvalid, m_tuser, m_tlast, m_tdata},
                   {21'd0, 1'b1, e.u, e.l, 6'd0, e.d});
      else     chk($sformatf("slot%0d_idle", pulses_done), {31'd0, m_tvalid}, 32'd0);
    end
    @(posedge clk_16M384);
    #1;
    if (rdy) pulses_done++;
    if (acc_s) begin
      fifo_q.delete(0);
      byte_idx++;
      accepted++;
    end
    s_tvalid = (fifo_q.size() > 0) && !(byte_idx == hold_idx && pulses_done < hold_until);
    s_tdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic run_frame(input logic [15:0] len, input int hk, input int hw, input bit prestarted,
                           input bit chain, input logic [15:0] next_len, input int abort_at);
    slot_t s;
    logic [7:0] v;
    logic [31:0] pw;
    int nslots;
    pw = PW;
    exp_q.delete();
    for (int i = 0; i < PL; i++) begin
      s.v = 1'b1; s.u = 1'b1; s.l = 1'b0; s.d = {pw[PL-1-i], pw[PL-1-i]};
      exp_q.push_back(s);
    end
    for (int i = 0; i < 16; i++) begin
      s.v = 1'b1; s.u = 1'b1; s.l = (len == 16'd0) && (i == 15); s.d = {len[15-i], len[15-i]};
      exp_q.push_back(s);
    end
    for (int j = 0; j < int'(len); j++) begin
      if (hw > 0 && j == hk) begin
        for (int w = 0; w < hw; w++) exp_q.push_back(5'd0);
      end
      v = pay_bytes[j] ^ ks_byte(j);
      for (int p = 0; p < 4; p++) begin
        s.v = 1'b1; s.u = 1'b0; s.l = (j == int'(len) - 1) && (p == 3); s.d = v[7-2*p -: 2];
        exp_q.push_back(s);
      end
    end
    for (int g = 0; g < GAP; g++) exp_q.push_back(5'd0);

    fifo_q = pay_bytes;
    byte_idx = 0; accepted = 0; tready_cycles = 0; pulses_done = 0;
    hold_idx   = (hw > 0) ? hk : -1;
    hold_until = 48 + 4 * hk + hw;
    if (!prestarted) begin
      frame_len = len;
      start = 1'b1;
      tick(1'b0);
      start = 1'b0;
    end
    nslots = exp_q.size();
    for (int n = 0; n < nslots; n++) begin
      if (n == abort_at) begin
        rstn_16M384 = 1'b0;
        #1;
        chk("rst_outs", {17'd0, busy, done, s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, underrun_err}, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        hold_idx = -1;
        s_tvalid = 1'b0;
        tick(1'b0);
        tick(1'b0);
        rstn_16M384 = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        return;
      end
      for (int t = 0; t < 15; t++) begin
        // Starts during PRE (slot 5) and HDR (slot 40) must be ignored
        if ((n == 5 || n == 40) && t == 7) begin
          start = 1'b1;
          frame_len = 16'($urandom());
        end
        tick(1'b0);
        start = 1'b0;
      end
      tick(1'b1);
    end
    chk("uerr", {31'd0, underrun_err}, {31'd0, hw > 0});
    if (chain) begin
      frame_len = next_len;
      start = 1'b1;
    end
    tick(1'b0);
    start = 1'b0;
    chk("done", {31'd0, obs_done}, 32'd1);
    chk("busy_done", {31'd0, obs_busy}, 32'd0);
    tick(1'b0);
    chk("done_pulse", {31'd0, obs_done}, 32'd0);
    chk("busy_after", {31'd0, obs_busy}, {31'd0, chain});
    chk("bytes", 32'(accepted), 32'(len));
    if (len == 16'd0) chk("tready_len0", 32'(tready_cycles), 32'd0);
    clear_err = 1'b1;
    tick(1'b0);
    clear_err = 1'b0;
    chk("uerr_clr", {31'd0, underrun_err}, 32'd0);
  endtask

  initial begin
    int len, hw, hk;
    rstn_16M384 = 1'b0;
    start = 1'b0; frame_len = 16'd0; s_tdata = 8'd0; s_tvalid = 1'b0;
    m_tready = 1'b0; clear_err = 1'b0;
    hold_idx = -1; hold_until = 0; byte_idx = 0; pulses_done = 0;
    accepted = 0; tready_cycles = 0;
    tick(1'b0);
    tick(1'b0);
    rstn_16M384 = 1'b1;
    tick(1'b0);
    chk("reset_outs", {17'd0, busy, done, s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, underrun_err}, 32'd0);

    pay_bytes = '{8'hB4, 8'h1E};
    run_frame(16'd2, 0, 0, 1'b0, 1'b0, 16'd0, -1);

    pay_bytes.delete();
    run_frame(16'd0, 0, 0, 1'b0, 1'b0, 16'd0, -1);

    pay_bytes.delete();
    for (int i = 0; i < 3; i++) pay_bytes.push_back(8'($urandom_range(0, 255)));
    run_frame(16'd3, 1, 3, 1'b0, 1'b1, 16'd2, -1);

    pay_bytes = '{8'h00, 8'h00};
    run_frame(16'd2, 0, 0, 1'b1, 1'b0, 16'd0, -1);

    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 5);
      hw  = (len > 1) ? $urandom_range(0, 3) : 0;
      hk  = (len > 1) ? $urandom_range(1, len - 1) : 0;
      pay_bytes.delete();
      for (int i = 0; i < len; i++) pay_bytes.push_back(8'($urandom_range(0, 255)));
      run_frame(16'(len), hk, hw, 1'b0, 1'b0, 16'd0, -1);
    end

    pay_bytes.delete();
    for (int i = 0; i < 4; i++) pay_bytes.push_back(8'($urandom_range(0, 255)));
    run_frame(16'd4, 0, 0, 1'b0, 1'b0, 16'd0, 50);

    pay_bytes.delete();
    pay_bytes.push_back(8'($urandom_range(0, 255)));
    run_frame(16'd1, 0, 0, 1'b0, 1'b0, 16'd0, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
